// File: rtl/adc_capture_buffer_if.sv
// ADC input stream and replay AXI-Stream bundle for one capture channel.
// The master side is the capture buffer; the slave side is its environment.
interface adc_capture_buffer_if #(
    parameter int ps_axis_width = 128
) ();
    logic [ps_axis_width-1:0] s_adc_tdata;
    logic                     s_adc_tvalid;
    logic [ps_axis_width-1:0] m_axis_tdata;
    logic                     m_axis_tvalid;
    logic                     m_axis_tready;

    modport master (
        input  s_adc_tdata,
        input  s_adc_tvalid,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        output s_adc_tdata,
        output s_adc_tvalid,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/adc_capture_buffer.sv
// Arm/trigger capture of ADC words into a simple-dual-port RAM, then in-order
// replay on AXI-Stream with full backpressure and a done pulse.
module adc_capture_buffer #(
    parameter int ps_axis_width = 128,
    parameter int depth_log2    = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic                  abort,
    input  logic [depth_log2:0]   capture_len,
    adc_capture_buffer_if.master  bus,
    output logic [1:0]            state_out,
    output logic                  done
);
    localparam logic [depth_log2:0] DEPTH = {1'b1, {depth_log2{1'b0}}};
    localparam logic [depth_log2:0] ONE   = {{depth_log2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                   state;
    logic [depth_log2:0]      len;
    logic [depth_log2:0]      wr_cnt;
    logic [depth_log2:0]      rd_ptr;
    logic [depth_log2:0]      hs_cnt;

    logic [ps_axis_width-1:0] mem [0:(1<<depth_log2)-1];

    logic                     wr_en;
    logic                     rd_en_p0;
    logic [ps_axis_width-1:0] ram_q_p1;
    logic                     vld_p1;
    logic [ps_axis_width-1:0] skid_data_p2;
    logic                     skid_vld_p2;
    logic [ps_axis_width-1:0] out_data_p2;
    logic                     out_vld_p2;
    logic                     pop;
    logic                     load_out;
    logic [1:0]               occ_next;

    function automatic logic [depth_log2:0] clamp_len(input logic [depth_log2:0] l);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    assign pop      = out_vld_p2 && bus.m_axis_tready;
    assign load_out = !out_vld_p2 || pop;
    // Words still held downstream after this cycle; a new read may only be
    // issued if its data will find room in the output or skid register.
    assign occ_next = {1'b0, out_vld_p2} + {1'b0, skid_vld_p2} + {1'b0, vld_p1} - {1'b0, pop};

    assign wr_en    = rstn && !abort && bus.s_adc_tvalid &&
                      ((state == ARMED && trigger) || state == CAPTURE);
    assign rd_en_p0 = (state == DRAIN) && !abort && (rd_ptr != len) && (occ_next <= 2'd1);

    // Stage p0 -> p1: RAM write port and registered read port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[depth_log2-1:0]] <= bus.s_adc_tdata;
        if (rd_en_p0) ram_q_p1 <= mem[rd_ptr[depth_log2-1:0]];
    end

    // Stage p1 -> p2: control FSM plus output/skid registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            len         <= '0;
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            hs_cnt      <= '0;
            vld_p1      <= 1'b0;
            skid_vld_p2 <= 1'b0;
            out_vld_p2  <= 1'b0;
            out_data_p2 <= '0;
            done        <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_p1 <= rd_en_p0;
            if (abort) begin
                state       <= IDLE;
                wr_cnt      <= '0;
                rd_ptr      <= '0;
                hs_cnt      <= '0;
                vld_p1      <= 1'b0;
                skid_vld_p2 <= 1'b0;
                out_vld_p2  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm && capture_len != '0) begin
                            len    <= clamp_len(capture_len);
                            wr_cnt <= '0;
                            rd_ptr <= '0;
                            hs_cnt <= '0;
                            state  <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (trigger) begin
                            state <= CAPTURE;
                            if (bus.s_adc_tvalid) begin
                                wr_cnt <= ONE;
                                if (len == ONE) state <= DRAIN;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (bus.s_adc_tvalid) begin
                            wr_cnt <= wr_cnt + ONE;
                            if (wr_cnt + ONE == len) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (rd_en_p0) rd_ptr <= rd_ptr + ONE;
                        if (load_out) begin
                            if (skid_vld_p2) begin
                                out_data_p2  <= skid_data_p2;
                                out_vld_p2   <= 1'b1;
                                skid_vld_p2  <= vld_p1;
                                skid_data_p2 <= ram_q_p1;
                            end else begin
                                if (vld_p1) out_data_p2 <= ram_q_p1;
                                out_vld_p2 <= vld_p1;
                            end
                        end else if (vld_p1) begin
                            skid_data_p2 <= ram_q_p1;
                            skid_vld_p2  <= 1'b1;
                        end
                        if (pop) begin
                            hs_cnt <= hs_cnt + ONE;
                            if (hs_cnt == len - ONE) begin
                                state       <= IDLE;
                                done        <= 1'b1;
                                out_vld_p2  <= 1'b0;
                                skid_vld_p2 <= 1'b0;
                                vld_p1      <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.m_axis_tdata  = out_data_p2;
    assign bus.m_axis_tvalid = out_vld_p2;
    assign state_out         = state;
endmodule
